arith_issue_queue: RTL and testbench
====================================

ARITH_ISSUE_QUEUE -- requirements
Module: arith_issue_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-002 Parameter CDB_NUM, default 2, number of result broadcast channels snooped.
REQ-003 Parameter ROB_W, default 4, ROB tag width; tag 0 means "operand ready".
REQ-004 Parameter DATA_W, default 32, operand width; OP_W, default 6, opcode width.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rdy  in  1  global enable; low freezes all state.
REQ-008 flush  in  1  misprediction clear.
REQ-009 disp_valid  in  1  dispatch request.
REQ-010 disp_op  in  OP_W; disp_q1, disp_q2  in  ROB_W; disp_v1, disp_v2  in  DATA_W; disp_pc, disp_imm  in  32; disp_rob_id  in  ROB_W.
REQ-011 cdb_valid  in  CDB_NUM; cdb_rob_id  in  CDB_NUM*ROB_W; cdb_data  in  CDB_NUM*DATA_W; channel k occupies slice k.
REQ-012 issue_valid  out  1; issue_ready  in  1  issue handshake to ALU.
REQ-013 issue_op  out  OP_W; issue_v1, issue_v2  out  DATA_W; issue_imm, issue_pc  out  32; issue_rob_id  out  ROB_W.
REQ-014 full  out  1; count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-015 Dispatch SHALL be accepted iff disp_valid && !full && rdy && !flush; accepted instruction SHALL occupy lowest-index free entry.
REQ-016 At acceptance, an operand whose tag matches any valid CDB channel in the same cycle SHALL be stored with tag 0 and that channel's data.
REQ-017 Every cycle with rdy high, every busy entry whose Q1/Q2 matches a valid CDB channel SHALL set that tag to 0 and capture the data; all channels and both operands SHALL be checked.
REQ-018 Tag 0 SHALL never be treated as a CDB match.
REQ-019 An entry SHALL be issue-eligible when busy and both stored tags are 0 at the start of the cycle; no same-cycle wakeup-and-issue.
REQ-020 Among eligible entries, the oldest by acceptance order SHALL be selected, independent of entry index.
REQ-021 Output register SHALL load when rdy && (!issue_valid || issue_ready) and an eligible entry exists; selected entry SHALL be freed that cycle.
REQ-022 If output register loads nothing while (!issue_valid || issue_ready), issue_valid SHALL go 0 next cycle.
REQ-023 While issue_valid && !issue_ready, all issue_* outputs SHALL hold stable.
REQ-024 count SHALL update each cycle by +1 per accept, -1 per issue; simultaneous accept and issue SHALL leave count unchanged.
REQ-025 full SHALL equal (count == DEPTH), combinationally from registered count; an entry freed this cycle SHALL be reusable next cycle only.
REQ-026 flush with rdy high SHALL clear all entries, count, and issue_valid next edge, overriding dispatch, wakeup and issue.
REQ-027 rdy low SHALL hold all entries, count and outputs; CDB broadcasts during rdy low are not captured.
REQ-028 Single-cycle latency: an accept with ready operands SHALL yield issue_valid no earlier than the second following edge.

Reset
REQ-029 rst high SHALL asynchronously clear all busy bits, age state, count=0, issue_valid=0, issue_* data fields=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries and any held issue without completing the handshake.

Verification
REQ-031 Dispatch tag 3 with q1=q2=0, v1=5, v2=7, issue_ready=1 -> issue_valid=1 two edges later, issue_v1=5, issue_v2=7, issue_rob_id=3, count back to 0.
REQ-032 Dispatch rob 1 with q1=4, then rob 2 ready; cdb ch1 broadcasts tag 4 data 0x55 -> rob 2 issues first, then rob 1 with issue_v1=0x55.
REQ-033 Fill DEPTH entries all waiting on tag 9 -> full=1, extra dispatch ignored; broadcast tag 9 -> entries issue in acceptance order, one per cycle, count decrements to 0.
REQ-034 Hold issue_ready=0 with 3 ready entries -> issue outputs stable, count stays 2 after first load; release -> remaining two issue consecutively.
REQ-035 Dispatch q2=6 in same cycle cdb ch0 broadcasts tag 6 data 0xAB -> entry issues with issue_v2=0xAB without further broadcast.
REQ-036 Assert flush (or rst) with 5 entries and issue_valid=1 -> next cycle count=0, issue_valid=0, full=0; later dispatch accepted into entry 0.

Source files
------------

// File: rtl/arith_issue_queue.sv
// arith_issue_queue: reservation station for the integer ALU.
// Entries wait for operand tags to be broadcast on the CDB and issue oldest-first
// through a single registered output stage with a valid/ready handshake.
module arith_issue_queue #(
  parameter  int DEPTH   = 16,
  parameter  int CDB_NUM = 2,
  parameter  int ROB_W   = 4,
  parameter  int DATA_W  = 32,
  parameter  int OP_W    = 6,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        disp_valid,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [ROB_W-1:0]            disp_q1,
  input  logic [ROB_W-1:0]            disp_q2,
  input  logic [DATA_W-1:0]           disp_v1,
  input  logic [DATA_W-1:0]           disp_v2,
  input  logic [31:0]                 disp_pc,
  input  logic [31:0]                 disp_imm,
  input  logic [ROB_W-1:0]            disp_rob_id,
  input  logic [CDB_NUM-1:0]          cdb_valid,
  input  logic [CDB_NUM*ROB_W-1:0]    cdb_rob_id,
  input  logic [CDB_NUM*DATA_W-1:0]   cdb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_op,
  output logic [DATA_W-1:0]           issue_v1,
  output logic [DATA_W-1:0]           issue_v2,
  output logic [31:0]                 issue_imm,
  output logic [31:0]                 issue_pc,
  output logic [ROB_W-1:0]            issue_rob_id,
  output logic                        full,
  output logic [CNT_W-1:0]            count
);

  // A tag matches a broadcast only when the channel is valid; tag 0 means "already ready".
  function automatic logic cdb_match(input logic [ROB_W-1:0] tag, input logic valid,
                                     input logic [ROB_W-1:0] id);
    return valid && (tag != '0) && (tag == id);
  endfunction

  // Entry storage; older_q[i] holds the set of entries accepted before entry i.
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [ROB_W-1:0]  q1_q    [DEPTH];
  logic [ROB_W-1:0]  q1_d    [DEPTH];
  logic [ROB_W-1:0]  q2_q    [DEPTH];
  logic [ROB_W-1:0]  q2_d    [DEPTH];
  logic [DATA_W-1:0] v1_q    [DEPTH];
  logic [DATA_W-1:0] v1_d    [DEPTH];
  logic [DATA_W-1:0] v2_q    [DEPTH];
  logic [DATA_W-1:0] v2_d    [DEPTH];
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       pc_d    [DEPTH];
  logic [31:0]       imm_q   [DEPTH];
  logic [31:0]       imm_d   [DEPTH];
  logic [ROB_W-1:0]  rob_q   [DEPTH];
  logic [ROB_W-1:0]  rob_d   [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic              issue_valid_q, issue_valid_d;
  logic [OP_W-1:0]   issue_op_q, issue_op_d;
  logic [DATA_W-1:0] issue_v1_q, issue_v1_d, issue_v2_q, issue_v2_d;
  logic [31:0]       issue_pc_q, issue_pc_d, issue_imm_q, issue_imm_d;
  logic [ROB_W-1:0]  issue_rob_q, issue_rob_d;

  logic [IDX_W-1:0]  alloc_idx_s, sel_idx_s;
  logic              alloc_ok_s, sel_ok_s;
  logic [DEPTH-1:0]  elig_s, oldest_s;
  logic [ROB_W-1:0]  dq1_s, dq2_s;
  logic [DATA_W-1:0] dv1_s, dv2_s;
  logic              accept_s, load_en_s, issue_s;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign count        = count_q;
  assign issue_valid  = issue_valid_q;
  assign issue_op     = issue_op_q;
  assign issue_v1     = issue_v1_q;
  assign issue_v2     = issue_v2_q;
  assign issue_pc     = issue_pc_q;
  assign issue_imm    = issue_imm_q;
  assign issue_rob_id = issue_rob_q;

  assign accept_s  = disp_valid & ~full & rdy & ~flush;
  assign load_en_s = rdy & ~flush & (~issue_valid_q | issue_ready);
  assign issue_s   = load_en_s & sel_ok_s;

  // Lowest-index free slot, judged on registered busy bits so a slot freed this cycle waits.
  always_comb begin
    alloc_ok_s  = 1'b0;
    alloc_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_ok_s  = alloc_ok_s | ~busy_q[i];
      alloc_idx_s = busy_q[i] ? alloc_idx_s : IDX_W'(i);
    end
  end

  // Oldest eligible entry: ready at start of cycle and no eligible entry older than it.
  always_comb begin
    elig_s    = '0;
    oldest_s  = '0;
    sel_ok_s  = 1'b0;
    sel_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig_s[i] = busy_q[i] & (q1_q[i] == '0) & (q2_q[i] == '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      oldest_s[i] = elig_s[i] & ((elig_s & older_q[i]) == '0);
      sel_ok_s    = sel_ok_s | oldest_s[i];
      sel_idx_s   = oldest_s[i] ? IDX_W'(i) : sel_idx_s;
    end
  end

  // Operands arriving at dispatch pick up a same-cycle broadcast of their tag.
  always_comb begin
    dq1_s = disp_q1;
    dq2_s = disp_q2;
    dv1_s = disp_v1;
    dv2_s = disp_v2;
    for (int k = 0; k < CDB_NUM; k++) begin
      dv1_s = cdb_match(disp_q1, cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W]) ?
              cdb_data[k*DATA_W +: DATA_W] : dv1_s;
      dq1_s = cdb_match(disp_q1, cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W]) ? '0 : dq1_s;
      dv2_s = cdb_match(disp_q2, cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W]) ?
              cdb_data[k*DATA_W +: DATA_W] : dv2_s;
      dq2_s = cdb_match(disp_q2, cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W]) ? '0 : dq2_s;
    end
  end

  // Next state: flush overrides everything; otherwise wakeup, issue and dispatch together.
  always_comb begin
    busy_d        = busy_q;
    older_d       = older_q;
    op_d          = op_q;
    q1_d          = q1_q;
    q2_d          = q2_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    rob_d         = rob_q;
    count_d       = count_q;
    issue_valid_d = issue_valid_q;
    issue_op_d    = issue_op_q;
    issue_v1_d    = issue_v1_q;
    issue_v2_d    = issue_v2_q;
    issue_pc_d    = issue_pc_q;
    issue_imm_d   = issue_imm_q;
    issue_rob_d   = issue_rob_q;
    if (rdy && flush) begin
      busy_d        = '0;
      count_d       = '0;
      issue_valid_d = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < CDB_NUM; k++) begin
          v1_d[i] = (busy_q[i] && cdb_match(q1_q[i], cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W])) ?
                    cdb_data[k*DATA_W +: DATA_W] : v1_d[i];
          q1_d[i] = (busy_q[i] && cdb_match(q1_q[i], cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W])) ?
                    '0 : q1_d[i];
          v2_d[i] = (busy_q[i] && cdb_match(q2_q[i], cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W])) ?
                    cdb_data[k*DATA_W +: DATA_W] : v2_d[i];
          q2_d[i] = (busy_q[i] && cdb_match(q2_q[i], cdb_valid[k], cdb_rob_id[k*ROB_W +: ROB_W])) ?
                    '0 : q2_d[i];
        end
      end
      if (load_en_s) begin
        if (sel_ok_s) begin
          busy_d[sel_idx_s] = 1'b0;
          issue_valid_d     = 1'b1;
          issue_op_d        = op_q[sel_idx_s];
          issue_v1_d        = v1_q[sel_idx_s];
          issue_v2_d        = v2_q[sel_idx_s];
          issue_pc_d        = pc_q[sel_idx_s];
          issue_imm_d       = imm_q[sel_idx_s];
          issue_rob_d       = rob_q[sel_idx_s];
        end else begin
          issue_valid_d = 1'b0;
        end
      end else begin
        issue_valid_d = issue_valid_q;
      end
      if (accept_s && alloc_ok_s) begin
        busy_d[alloc_idx_s]  = 1'b1;
        op_d[alloc_idx_s]    = disp_op;
        q1_d[alloc_idx_s]    = dq1_s;
        q2_d[alloc_idx_s]    = dq2_s;
        v1_d[alloc_idx_s]    = dv1_s;
        v2_d[alloc_idx_s]    = dv2_s;
        pc_d[alloc_idx_s]    = disp_pc;
        imm_d[alloc_idx_s]   = disp_imm;
        rob_d[alloc_idx_s]   = disp_rob_id;
        older_d[alloc_idx_s] = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
          older_d[i][alloc_idx_s] = 1'b0;
        end
        count_d = count_q + CNT_W'(1) - CNT_W'(issue_s);
      end else begin
        count_d = count_q - CNT_W'(issue_s);
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_v1_q    <= '0;
      issue_v2_q    <= '0;
      issue_pc_q    <= '0;
      issue_imm_q   <= '0;
      issue_rob_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older_q[i] <= '0;
        op_q[i]    <= '0;
        q1_q[i]    <= '0;
        q2_q[i]    <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= '0;
        rob_q[i]   <= '0;
      end
    end else begin
      busy_q        <= busy_d;
      older_q       <= older_d;
      op_q          <= op_d;
      q1_q          <= q1_d;
      q2_q          <= q2_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      rob_q         <= rob_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_op_q    <= issue_op_d;
      issue_v1_q    <= issue_v1_d;
      issue_v2_q    <= issue_v2_d;
      issue_pc_q    <= issue_pc_d;
      issue_imm_q   <= issue_imm_d;
      issue_rob_q   <= issue_rob_d;
    end
  end

endmodule

// File: tb/tb_arith_issue_queue.sv
// tb_arith_issue_queue: directed scenarios plus randomized traffic against an
// in-order queue reference model of the issue queue.
module tb_arith_issue_queue;
  localparam int DEPTH = 16, CDB_NUM = 2, ROB_W = 4, DATA_W = 32, OP_W = 6;

  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush = 1'b0, disp_valid = 1'b0;
  logic [OP_W-1:0] disp_op = '0;
  logic [ROB_W-1:0] disp_q1 = '0, disp_q2 = '0, disp_rob_id = '0;
  logic [DATA_W-1:0] disp_v1 = '0, disp_v2 = '0;
  logic [31:0] disp_pc = '0, disp_imm = '0;
  logic [CDB_NUM-1:0] cdb_valid = '0;
  logic [CDB_NUM*ROB_W-1:0] cdb_rob_id = '0;
  logic [CDB_NUM*DATA_W-1:0] cdb_data = '0;
  logic issue_valid, issue_ready = 1'b1, full;
  logic [OP_W-1:0] issue_op;
  logic [DATA_W-1:0] issue_v1, issue_v2;
  logic [31:0] issue_imm, issue_pc;
  logic [ROB_W-1:0] issue_rob_id;
  logic [4:0] count;

  int checks = 0, errors = 0;

  arith_issue_queue #(.DEPTH(DEPTH), .CDB_NUM(CDB_NUM), .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .disp_valid(disp_valid),
    .disp_op(disp_op), .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_id(issue_rob_id), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: instructions kept in acceptance order in a queue.
  typedef struct packed {
    logic [OP_W-1:0] op; logic [ROB_W-1:0] q1, q2; logic [DATA_W-1:0] v1, v2;
    logic [31:0] pc, imm; logic [ROB_W-1:0] rob;
  } ent_t;
  ent_t mq[$];
  ent_t m_out;
  logic m_valid;

  function automatic void model_clear();
    mq.delete();
    m_valid = 1'b0;
  endfunction

  // One clock of the model, computed from the inputs currently applied.
  function automatic void model_step();
    ent_t e;
    int sel, start_size;
    logic [ROB_W-1:0] t;
    if (!rdy) return;
    if (flush) begin
      model_clear();
      return;
    end
    start_size = mq.size();
    if (!m_valid || issue_ready) begin
      sel = -1;
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && mq[i].q1 == '0 && mq[i].q2 == '0) sel = i;
      if (sel >= 0) begin
        m_out = mq[sel];
        mq.delete(sel);
        m_valid = 1'b1;
      end else m_valid = 1'b0;
    end
    for (int i = 0; i < mq.size(); i++)
      for (int k = 0; k < CDB_NUM; k++) begin
        t = cdb_rob_id[k*ROB_W +: ROB_W];
        if (cdb_valid[k] && t != '0 && mq[i].q1 == t) begin mq[i].q1 = '0; mq[i].v1 = cdb_data[k*DATA_W +: DATA_W]; end
        if (cdb_valid[k] && t != '0 && mq[i].q2 == t) begin mq[i].q2 = '0; mq[i].v2 = cdb_data[k*DATA_W +: DATA_W]; end
      end
    if (disp_valid && start_size < DEPTH) begin
      e = '{op: disp_op, q1: disp_q1, q2: disp_q2, v1: disp_v1, v2: disp_v2,
            pc: disp_pc, imm: disp_imm, rob: disp_rob_id};
      for (int k = 0; k < CDB_NUM; k++) begin
        t = cdb_rob_id[k*ROB_W +: ROB_W];
        if (cdb_valid[k] && t != '0 && disp_q1 == t) begin e.q1 = '0; e.v1 = cdb_data[k*DATA_W +: DATA_W]; end
        if (cdb_valid[k] && t != '0 && disp_q2 == t) begin e.q2 = '0; e.v2 = cdb_data[k*DATA_W +: DATA_W]; end
      end
      mq.push_back(e);
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic set_disp(input logic [ROB_W-1:0] q1, input logic [ROB_W-1:0] q2,
                          input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                          input logic [ROB_W-1:0] rob);
    disp_valid = 1'b1; disp_op = OP_W'(rob) + 6'd1; disp_q1 = q1; disp_q2 = q2;
    disp_v1 = v1; disp_v2 = v2; disp_pc = 32'h1000 + 32'(rob); disp_imm = 32'h40 + 32'(rob);
    disp_rob_id = rob;
  endtask

  task automatic test_reset();
    idle(); issue_ready = 1'b1; rst = 1'b1; model_clear();
    #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", issue_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (issue_v1 !== 32'd0 || issue_rob_id !== 4'd0) begin errors++;
      $display("FAIL reset_data: got v1=%0h rob=%0d expected 0", issue_v1, issue_rob_id); end
    @(posedge clk); #1; rst = 1'b0; m_out = '0;
  endtask

  task automatic test_basic();
    idle(); issue_ready = 1'b1;
    set_disp(4'd0, 4'd0, 32'd5, 32'd7, 4'd3);
    tick(); disp_valid = 1'b0;
    checks++; if (issue_valid !== 1'b0 || count !== 5'd1) begin errors++;
      $display("FAIL basic_latency: got valid=%0b count=%0d expected 0/1", issue_valid, count); end
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_v1 !== 32'd5 || issue_v2 !== 32'd7 || issue_rob_id !== 4'd3 || count !== 5'd0) begin
      errors++; $display("FAIL basic_issue: got valid=%0b v1=%0d v2=%0d rob=%0d count=%0d expected 1/5/7/3/0",
                         issue_valid, issue_v1, issue_v2, issue_rob_id, count); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_cdb_order();
    idle(); issue_ready = 1'b1;
    set_disp(4'd4, 4'd0, 32'd0, 32'h11, 4'd1); tick();
    set_disp(4'd0, 4'd0, 32'h22, 32'h23, 4'd2); tick();
    disp_valid = 1'b0; cdb_valid = 2'b10; cdb_rob_id = {4'd4, 4'd0}; cdb_data = {32'h55, 32'h0};
    tick(); cdb_valid = '0;
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd2) begin errors++;
      $display("FAIL order_first: got valid=%0b rob=%0d expected 1/2", issue_valid, issue_rob_id); end
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd1 || issue_v1 !== 32'h55) begin errors++;
      $display("FAIL order_wakeup: got valid=%0b rob=%0d v1=%0h expected 1/1/55", issue_valid, issue_rob_id, issue_v1); end
    tick();
    checks++; if (issue_valid !== 1'b0 || count !== 5'd0) begin errors++;
      $display("FAIL order_drain: got valid=%0b count=%0d expected 0/0", issue_valid, count); end
  endtask

  task automatic test_full();
    idle(); issue_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(4'd9, 4'd0, 32'hdead0000 + 32'(i), 32'(i), ROB_W'(i));
      tick();
    end
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++;
      $display("FAIL full_flag: got count=%0d full=%0b expected 16/1", count, full); end
    set_disp(4'd0, 4'd0, 32'h1, 32'h2, 4'd15); tick(); disp_valid = 1'b0;
    checks++; if (count !== 5'd16 || issue_valid !== 1'b0) begin errors++;
      $display("FAIL full_reject: got count=%0d valid=%0b expected 16/0", count, issue_valid); end
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h99};
    tick(); cdb_valid = '0;
    checks++; if (issue_valid !== 1'b0) begin errors++;
      $display("FAIL full_same_cycle_issue: got %0b expected 0", issue_valid); end
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_rob_id !== ROB_W'(k) || issue_v1 !== 32'h99 || count !== 5'(DEPTH - 1 - k)) begin
        errors++; $display("FAIL full_drain_%0d: got valid=%0b rob=%0d v1=%0h count=%0d expected 1/%0d/99/%0d",
                           k, issue_valid, issue_rob_id, issue_v1, count, k, DEPTH - 1 - k); end
    end
    tick();
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin errors++;
      $display("FAIL full_empty: got valid=%0b full=%0b expected 0/0", issue_valid, full); end
  endtask

  task automatic test_backpressure();
    idle(); issue_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_disp(4'd0, 4'd0, 32'h100 + 32'(i), 32'h200 + 32'(i), ROB_W'(i));
      tick();
    end
    disp_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd1 || issue_v1 !== 32'h101 || issue_pc !== 32'h1001 || count !== 5'd2) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%0b rob=%0d v1=%0h pc=%0h count=%0d expected 1/1/101/1001/2",
                           n, issue_valid, issue_rob_id, issue_v1, issue_pc, count); end
      tick();
    end
    issue_ready = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_rob_id !== ROB_W'(i) || count !== 5'(3 - i)) begin errors++;
        $display("FAIL bp_release_%0d: got valid=%0b rob=%0d count=%0d expected 1/%0d/%0d", i, issue_valid, issue_rob_id, count, i, 3 - i); end
    end
    tick();
  endtask

  task automatic test_capture();
    idle(); issue_ready = 1'b1;
    set_disp(4'd0, 4'd6, 32'h1, 32'h1234, 4'd7);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd6}; cdb_data = {32'h0, 32'hAB};
    tick(); idle(); tick();
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd7 || issue_v2 !== 32'hAB) begin errors++;
      $display("FAIL capture: got valid=%0b rob=%0d v2=%0h expected 1/7/ab", issue_valid, issue_rob_id, issue_v2); end
    tick();
  endtask

  task automatic test_flush();
    idle(); issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin set_disp(4'd0, 4'd0, 32'(i), 32'(i), ROB_W'(i + 1)); tick(); end
    disp_valid = 1'b0;
    checks++; if (count !== 5'd5 || issue_valid !== 1'b1) begin errors++;
      $display("FAIL flush_setup: got count=%0d valid=%0b expected 5/1", count, issue_valid); end
    flush = 1'b1; set_disp(4'd0, 4'd0, 32'h9, 32'h9, 4'd9); tick(); idle();
    checks++; if (count !== 5'd0 || issue_valid !== 1'b0 || full !== 1'b0) begin errors++;
      $display("FAIL flush_clear: got count=%0d valid=%0b full=%0b expected 0/0/0", count, issue_valid, full); end
    issue_ready = 1'b1; set_disp(4'd0, 4'd0, 32'hA0, 32'hA1, 4'd10); tick(); idle(); tick();
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd10 || issue_v1 !== 32'hA0) begin errors++;
      $display("FAIL flush_reuse: got valid=%0b rob=%0d v1=%0h expected 1/10/a0", issue_valid, issue_rob_id, issue_v1); end
    tick(); issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin set_disp(4'd0, 4'd0, 32'(i), 32'(i), ROB_W'(i + 1)); tick(); end
    idle(); rst = 1'b1; model_clear(); #2;
    checks++; if (count !== 5'd0 || issue_valid !== 1'b0 || full !== 1'b0 || issue_rob_id !== 4'd0) begin errors++;
      $display("FAIL rst_mid: got count=%0d valid=%0b full=%0b rob=%0d expected 0/0/0/0", count, issue_valid, full, issue_rob_id); end
    @(posedge clk); #1; rst = 1'b0; m_out = '0;
    issue_ready = 1'b1; set_disp(4'd0, 4'd0, 32'hB0, 32'hB1, 4'd11); tick(); idle(); tick();
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd11) begin errors++;
      $display("FAIL rst_reuse: got valid=%0b rob=%0d expected 1/11", issue_valid, issue_rob_id); end
    tick();
  endtask

  task automatic test_rdy_low();
    idle(); issue_ready = 1'b1;
    set_disp(4'd3, 4'd0, 32'h0, 32'h5, 4'd5); tick();
    rdy = 1'b0; set_disp(4'd0, 4'd0, 32'h6, 32'h6, 4'd6);
    cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd3}; cdb_data = {32'h0, 32'h77};
    tick(); tick(); idle(); tick();
    checks++; if (count !== 5'd1 || issue_valid !== 1'b0) begin errors++;
      $display("FAIL rdy_hold: got count=%0d valid=%0b expected 1/0", count, issue_valid); end
    cdb_valid = 2'b10; cdb_rob_id = {4'd3, 4'd0}; cdb_data = {32'h88, 32'h0};
    tick(); idle(); tick();
    checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 4'd5 || issue_v1 !== 32'h88) begin errors++;
      $display("FAIL rdy_resume: got valid=%0b rob=%0d v1=%0h expected 1/5/88", issue_valid, issue_rob_id, issue_v1); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      issue_ready = ($urandom_range(0, 3) != 0);
      disp_valid = ($urandom_range(0, 2) != 0);
      disp_op = 6'($urandom);
      disp_q1 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      disp_q2 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      disp_v1 = $urandom; disp_v2 = $urandom; disp_pc = $urandom; disp_imm = $urandom;
      disp_rob_id = 4'($urandom_range(0, 15));
      cdb_valid = 2'($urandom_range(0, 3));
      cdb_rob_id = 8'($urandom); cdb_data = {$urandom, $urandom};
      if (cdb_rob_id[3:0] == cdb_rob_id[7:4]) cdb_valid[1] = 1'b0;
      tick();
      checks++; if (issue_valid !== m_valid || count !== 5'(mq.size()) || full !== (mq.size() == DEPTH)) begin errors++;
        $display("FAIL rand_ctrl_%0d: got valid=%0b count=%0d full=%0b expected %0b/%0d/%0b",
                 n, issue_valid, count, full, m_valid, mq.size(), mq.size() == DEPTH); end
      if (m_valid) begin
        checks++; if (issue_rob_id !== m_out.rob || issue_op !== m_out.op || issue_v1 !== m_out.v1 ||
                      issue_v2 !== m_out.v2 || issue_pc !== m_out.pc || issue_imm !== m_out.imm) begin errors++;
          $display("FAIL rand_data_%0d: got rob=%0d op=%0h v1=%0h v2=%0h pc=%0h imm=%0h expected %0d/%0h/%0h/%0h/%0h/%0h",
                   n, issue_rob_id, issue_op, issue_v1, issue_v2, issue_pc, issue_imm,
                   m_out.rob, m_out.op, m_out.v1, m_out.v2, m_out.pc, m_out.imm); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_order();
    test_full();
    test_backpressure();
    test_capture();
    test_flush();
    test_rdy_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
